// File: rtl/async_fifo.sv
// Same-clock FIFO that keeps the Gray-pointer / two-flop synchronizer structure of a dual-clock FIFO,
// so its flag latencies stay the same if the block is later split into two clock domains.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wbin, wgray, rbin, rgray;
  logic [ADDR_WIDTH:0] wbin_next, wgray_next, rbin_next, rgray_next;
  logic [ADDR_WIDTH:0] wq1, wq2, rq1, rq2;
  logic                wr_ok, rd_ok;
  logic                full_next, empty_next;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wr_ok};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, rd_ok};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_next  = (wgray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]});
  assign empty_next = (rgray_next == wq2);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wbin[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin  <= '0;
      wgray <= '0;
      rq1   <= '0;
      rq2   <= '0;
      full  <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      rq1   <= rgray;
      rq2   <= rq1;
      full  <= full_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin    <= '0;
      rgray   <= '0;
      wq1     <= '0;
      wq2     <= '0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      rbin  <= rbin_next;
      rgray <= rgray_next;
      wq1   <= wgray;
      wq2   <= wq1;
      empty <= empty_next;
      if (rd_ok) rd_data <= mem[rbin[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: written words are queued and compared as reads return them.
module tb_async_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       full, empty;
  logic [7:0] rd_data;

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];

  async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .rd_en(rd_en), .rd_data(rd_data), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Drive inputs on the falling edge, return 1 time unit after the next rising edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
    @(negedge clk);
    wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      total++;
      if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold: empty=%b full=%b rd_data=%h, want 1 0 00", empty, full, rd_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: empty=%b full=%b rd_data=%h, want 1 0 00", empty, full, rd_data);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp;
    idle(4);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      sb.push_back(8'(i));
      if (i == 15) begin
        total++;
        if (full !== 1'b1) begin
          bad++;
          $display("FAIL fill_full: full=%b, want 1", full);
        end
      end
      idle(1);
    end
    idle(10);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      exp = sb.pop_front();
      total++;
      if (rd_data !== exp) begin
        bad++;
        $display("FAIL drain_data[%0d]: rd_data=%h, want %h", i, rd_data, exp);
      end
      if (i == 15) begin
        total++;
        if (empty !== 1'b1) begin
          bad++;
          $display("FAIL drain_empty: empty=%b, want 1", empty);
        end
      end
      idle(1);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    idle(4);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      sb.push_back(8'(i));
    end
    cycle(1'b1, 8'hAA, 1'b0);
    total++;
    if (full !== 1'b1) begin
      bad++;
      $display("FAIL overflow_full: full=%b, want 1", full);
    end
    idle(4);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      exp = sb.pop_front();
      total++;
      if (rd_data !== exp) begin
        bad++;
        $display("FAIL overflow_data[%0d]: rd_data=%h, want %h", i, rd_data, exp);
      end
    end
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL overflow_empty: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] held, exp;
    idle(4);
    held = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      total++;
      if (rd_data !== held || empty !== 1'b1) begin
        bad++;
        $display("FAIL underflow[%0d]: rd_data=%h empty=%b, want %h 1", i, rd_data, empty, held);
      end
    end
    cycle(1'b1, 8'h5C, 1'b0);
    sb.push_back(8'h5C);
    idle(4);
    cycle(1'b0, 8'h00, 1'b1);
    exp = sb.pop_front();
    total++;
    if (rd_data !== exp || empty !== 1'b1) begin
      bad++;
      $display("FAIL underflow_after: rd_data=%h empty=%b, want %h 1", rd_data, empty, exp);
    end
  endtask

  task automatic test_flag_latency();
    logic [7:0] exp;
    idle(4);
    cycle(1'b1, 8'h11, 1'b0);
    sb.push_back(8'h11);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) idle(1);
      total++;
      if (empty !== (k < 3)) begin
        bad++;
        $display("FAIL empty_latency[N+%0d]: empty=%b, want %b", k, empty, (k < 3));
      end
    end
    for (int i = 1; i < 16; i++) begin
      cycle(1'b1, 8'(8'h20 + i), 1'b0);
      sb.push_back(8'(8'h20 + i));
    end
    idle(4);
    cycle(1'b0, 8'h00, 1'b1);
    exp = sb.pop_front();
    total++;
    if (rd_data !== exp) begin
      bad++;
      $display("FAIL full_release_data: rd_data=%h, want %h", rd_data, exp);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) idle(1);
      total++;
      if (full !== (k < 3)) begin
        bad++;
        $display("FAIL full_latency[N+%0d]: full=%b, want %b", k, full, (k < 3));
      end
    end
    while (sb.size() > 0) begin
      cycle(1'b0, 8'h00, 1'b1);
      exp = sb.pop_front();
      total++;
      if (rd_data !== exp) begin
        bad++;
        $display("FAIL latency_drain: rd_data=%h, want %h", rd_data, exp);
      end
    end
  endtask

  task automatic test_streaming();
    int nw, nr, cyc;
    logic we, re;
    logic [7:0] exp;
    idle(4);
    nw = 0; nr = 0; cyc = 0;
    while (nr < 40 && cyc < 600) begin
      @(negedge clk);
      we = (nw < 40) && !full;
      re = !empty;
      wr_en = we; wr_data = 8'(nw); rd_en = re;
      @(posedge clk);
      #1;
      cyc++;
      if (we) begin
        sb.push_back(8'(nw));
        nw++;
      end
      if (re) begin
        exp = sb.pop_front();
        nr++;
        total++;
        if (rd_data !== exp) begin
          bad++;
          $display("FAIL stream_data[%0d]: rd_data=%h, want %h", nr - 1, rd_data, exp);
        end
      end
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    total++;
    if (nr != 40 || nw != 40) begin
      bad++;
      $display("FAIL stream_count: reads=%0d writes=%0d, want 40 40", nr, nw);
    end
    idle(4);
    total++;
    if (empty !== 1'b1 || sb.size() != 0) begin
      bad++;
      $display("FAIL stream_end: empty=%b pending=%0d, want 1 0", empty, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    idle(2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
    idle(4);
    cycle(1'b0, 8'h00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset: empty=%b full=%b rd_data=%h, want 1 0 00", empty, full, rd_data);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_release: empty=%b, want 1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_flag_latency();
    test_streaming();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
